// File: rtl/irq_accept_ctrl_if.sv
// irq_accept_ctrl_if: bundles the interrupt handshake and the PC-redirect signals between
// the interrupt controller/core (master) and irq_accept_ctrl (slave).
//   irq, irq_addr        controller request (level) and handler vector
//   irq_ack              one-cycle acknowledge back to the controller
//   pc_next, stall, eret core status: next fetch PC, not-at-boundary, return-from-interrupt
//   ie_we, ie_wd         software write of the interrupt-enable bit
//   pc_redirect/_target  fetch redirect request and its target
//   epc, int_en          saved return PC and current interrupt enable
//   in_service           handler executing
//   irq_count, irq_lat_max  statistics, present only when IRQ_STATS_EN is defined
interface irq_accept_ctrl_if
`ifdef IRQ_STATS_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  logic        irq;
  logic [31:0] irq_addr;
  logic        irq_ack;
  logic [31:0] pc_next;
  logic        stall;
  logic        eret;
  logic        ie_we;
  logic        ie_wd;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic        int_en;
  logic        in_service;
`ifdef IRQ_STATS_EN
  logic [CNT_W-1:0] irq_count;
  logic [CNT_W-1:0] irq_lat_max;
`endif

  modport master (
    output irq, irq_addr, pc_next, stall, eret, ie_we, ie_wd,
    input  irq_ack, pc_redirect, pc_target, epc, int_en, in_service
`ifdef IRQ_STATS_EN
    , irq_count, irq_lat_max
`endif
  );

  modport slave (
    input  irq, irq_addr, pc_next, stall, eret, ie_we, ie_wd,
    output irq_ack, pc_redirect, pc_target, epc, int_en, in_service
`ifdef IRQ_STATS_EN
    , irq_count, irq_lat_max
`endif
  );
endinterface

// File: rtl/irq_accept_ctrl.sv
// irq_accept_ctrl: CPU-side interrupt acceptor. Takes a pending irq at an instruction
// boundary, redirects fetch to the handler vector, acknowledges the controller, saves the
// return PC in epc and masks further interrupts until eret, then redirects back to epc.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus_io   irq_accept_ctrl_if.slave (handshake, PC redirect, epc/int_en/in_service)
// Parameters:
//   IE_RESET reset value of the interrupt-enable bit
//   CNT_W    statistics counter width (only with IRQ_STATS_EN)
// Optional feature: define IRQ_STATS_EN to add the saturating irq_count and irq_lat_max
// statistics outputs.
module irq_accept_ctrl #(
  parameter bit IE_RESET = 1'b1
`ifdef IRQ_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input logic              clk,
  input logic              rst,
  irq_accept_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StAck, StService, StReturn} state_e;

  state_e      state_q;
  logic        pc_redirect_q;
  logic [31:0] pc_target_q;
  logic [31:0] epc_q;
  logic        in_service_q;
  logic        int_en_q;
  logic        irq_ack;

  // Vector low bits are forced to zero, so they are never looked at.
  logic unused_addr;
  assign unused_addr = ^bus_io.irq_addr[1:0];

  // The ack has to land on the ACK cycle whose stall is low, which is only known during that
  // cycle; it is the registered ACK state qualified by the live stall. Reset suppresses it.
  assign irq_ack = (state_q == StAck) && !bus_io.stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= 32'h0;
      epc_q         <= 32'h0;
      in_service_q  <= 1'b0;
      int_en_q      <= IE_RESET;
    end else begin
      if (bus_io.ie_we) begin
        int_en_q <= bus_io.ie_wd;
      end
      unique case (state_q)
        StIdle: begin
          // A same-cycle enable write blocks acceptance so the write takes effect first.
          if (int_en_q && bus_io.irq && !bus_io.stall && !bus_io.ie_we) begin
            epc_q         <= bus_io.pc_next;
            pc_target_q   <= {bus_io.irq_addr[31:2], 2'b00};
            pc_redirect_q <= 1'b1;
            state_q       <= StAck;
          end
        end
        StAck: begin
          if (!bus_io.stall) begin
            pc_redirect_q <= 1'b0;
            in_service_q  <= 1'b1;
            state_q       <= StService;
          end
        end
        StService: begin
          if (bus_io.eret) begin
            in_service_q  <= 1'b0;
            pc_redirect_q <= 1'b1;
            pc_target_q   <= epc_q;
            state_q       <= StReturn;
          end
        end
        StReturn: begin
          if (!bus_io.stall) begin
            pc_redirect_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.irq_ack     = irq_ack;
  assign bus_io.pc_redirect = pc_redirect_q;
  assign bus_io.pc_target   = pc_target_q;
  assign bus_io.epc         = epc_q;
  assign bus_io.int_en      = int_en_q;
  assign bus_io.in_service  = in_service_q;

`ifdef IRQ_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] lat_max_q;

  // lat_q counts every cycle from the first IDLE cycle with irq high through the ACK cycles,
  // so on the ack cycle it already equals the irq-to-ack latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      lat_q     <= '0;
      lat_max_q <= '0;
    end else if (irq_ack) begin
      if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (lat_q > lat_max_q) begin
        lat_max_q <= lat_q;
      end
      lat_q <= '0;
    end else if ((state_q == StIdle && bus_io.irq) || state_q == StAck) begin
      if (lat_q != CntMax) begin
        lat_q <= lat_q + CNT_W'(1);
      end
    end else begin
      lat_q <= '0;
    end
  end

  assign bus_io.irq_count   = cnt_q;
  assign bus_io.irq_lat_max = lat_max_q;
`endif

endmodule
